// File: rtl/uart_tx_fifo.sv
// UART transmitter with a valid/ready TX FIFO, run-time parity/stop-bit selection
// and an internal baud divider. Frames go out back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_en,
  input  logic [DIV_W-1:0]         baud_div,
  input  logic [1:0]               parity_mode,
  input  logic                     stop2,
  input  logic                     s_valid,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     s_ready,
  output logic                     txd,
  output logic                     busy,
  output logic                     tx_done,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic [1:0] mode);
    logic p;
    p = ^data;
    case (mode)
      2'b01:   return p;
      2'b10:   return ~p;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == 2'b01) || (mode == 2'b10);
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]     level_r, level_nxt_s;
  logic              s_ready_r, txd_r, busy_r, tx_done_r;
  state_t            state_r, state_nxt_s;
  logic [DIV_W-1:0]  cnt_r, cnt_nxt_s;
  logic [BW-1:0]     bit_idx_r, bit_idx_nxt_s;
  logic              stop_cnt_r, stop_cnt_nxt_s;
  logic [DATA_W-1:0] shift_r, shift_nxt_s;
  logic              par_bit_r, par_bit_nxt_s;
  logic              par_en_r, par_en_nxt_s;
  logic              stop2_r, stop2_nxt_s;
  logic              bit_end_s, frame_end_s, load_s, push_s;
  logic              txd_nxt_s, done_nxt_s;

  // Handshake, frame-boundary and FIFO-level decisions
  always_comb begin
    bit_end_s   = (cnt_r == baud_div);
    frame_end_s = (state_r == STOP) && bit_end_s && ((stop_cnt_r == 1'b1) || !stop2_r);
    load_s      = tx_en && (level_r != {LW{1'b0}}) && ((state_r == IDLE) || frame_end_s);
    push_s      = s_valid && s_ready_r;
    level_nxt_s = level_r + LW'(push_s) - LW'(load_s);
  end

  // Frame sequencer next state; a load overrides the end-of-frame transition
  always_comb begin
    state_nxt_s    = state_r;
    bit_idx_nxt_s  = bit_idx_r;
    stop_cnt_nxt_s = stop_cnt_r;
    shift_nxt_s    = shift_r;
    par_bit_nxt_s  = par_bit_r;
    par_en_nxt_s   = par_en_r;
    stop2_nxt_s    = stop2_r;
    if ((state_r != IDLE) && !bit_end_s) begin
      cnt_nxt_s = cnt_r + DIV_W'(1);
    end else begin
      cnt_nxt_s = {DIV_W{1'b0}};
    end
    case (state_r)
      IDLE: state_nxt_s = IDLE;
      START: begin
        if (bit_end_s) begin
          state_nxt_s   = DATA;
          bit_idx_nxt_s = {BW{1'b0}};
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (bit_end_s && (bit_idx_r == BW'(DATA_W - 1))) begin
          state_nxt_s    = par_en_r ? PARITY : STOP;
          stop_cnt_nxt_s = 1'b0;
        end else if (bit_end_s) begin
          bit_idx_nxt_s = bit_idx_r + BW'(1);
          shift_nxt_s   = shift_r >> 1;
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_nxt_s    = STOP;
          stop_cnt_nxt_s = 1'b0;
        end else begin
          state_nxt_s = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s && ((stop_cnt_r == 1'b1) || !stop2_r)) begin
          state_nxt_s = IDLE;
        end else if (bit_end_s) begin
          stop_cnt_nxt_s = 1'b1;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    // Configuration is captured only here, so mid-frame changes wait for the next frame
    if (load_s) begin
      state_nxt_s   = START;
      cnt_nxt_s     = {DIV_W{1'b0}};
      shift_nxt_s   = mem_r[rd_ptr_r];
      par_bit_nxt_s = calc_parity(mem_r[rd_ptr_r], parity_mode);
      par_en_nxt_s  = parity_enabled(parity_mode);
      stop2_nxt_s   = stop2;
    end else begin
      stop2_nxt_s = stop2_nxt_s;
    end
  end

  // Output values for the upcoming cycle, so txd/tx_done come straight from flops
  always_comb begin
    case (state_nxt_s)
      IDLE:    txd_nxt_s = 1'b1;
      START:   txd_nxt_s = 1'b0;
      DATA:    txd_nxt_s = shift_nxt_s[0];
      PARITY:  txd_nxt_s = par_bit_nxt_s;
      STOP:    txd_nxt_s = 1'b1;
      default: txd_nxt_s = 1'b1;
    endcase
    done_nxt_s = (state_nxt_s == STOP) && (cnt_nxt_s == baud_div) &&
                 ((stop_cnt_nxt_s == 1'b1) || !stop2_nxt_s);
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end
  end

  // Sequencer, FIFO pointer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {DIV_W{1'b0}};
      bit_idx_r  <= {BW{1'b0}};
      stop_cnt_r <= 1'b0;
      shift_r    <= {DATA_W{1'b0}};
      par_bit_r  <= 1'b0;
      par_en_r   <= 1'b0;
      stop2_r    <= 1'b0;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      s_ready_r  <= 1'b1;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      stop_cnt_r <= stop_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      par_bit_r  <= par_bit_nxt_s;
      par_en_r   <= par_en_nxt_s;
      stop2_r    <= stop2_nxt_s;
      wr_ptr_r   <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      rd_ptr_r   <= load_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
      level_r    <= level_nxt_s;
      s_ready_r  <= (level_nxt_s != LW'(DEPTH));
      txd_r      <= txd_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
      tx_done_r  <= done_nxt_s;
    end
  end

  assign s_ready    = s_ready_r;
  assign txd        = txd_r;
  assign busy       = busy_r;
  assign tx_done    = tx_done_r;
  assign fifo_level = level_r;

endmodule
